// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state qualify FSM and
// registered level plus single-cycle press/release strobes.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   btn_in      - raw asynchronous button, active-high, bouncing
//   btn_level   - debounced level (registered)
//   btn_press   - one-cycle press strobe (registered)
//   btn_release - one-cycle release strobe (registered)
//
// Parameters:
//   STABLE_CYCLES - cycles a level must hold before acceptance (2..2^24)
//   REPEAT_DELAY  - HELD cycles before first auto-repeat press
//   REPEAT_PERIOD - cycles between later auto-repeat presses
//
// Build option: define BTN_REPEAT_EN to enable auto-repeat while HELD.
// Without it only one btn_press is issued per qualified press.
module btn_debounce #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 2) begin : g_bad_param
    $error("btn_debounce: illegal parameter value");
  end

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          s1;
  logic          s2;
  logic          level_nxt;
  logic          press_nxt;
  logic          release_nxt;
  logic          rep_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;

  // rep_first marks that the initial delay has been served, so
  // later pulses use the shorter period.
  assign rep_hit = (state == HELD) && s2 &&
                   (rep_cnt == (rep_first ? RP_LAST : RD_LAST));

  // Any cycle not spent continuously in HELD restarts the delay,
  // including a bounce through RELEASE_WAIT.
  always_ff @(posedge clk) begin
    if (rst || state != HELD || state_nxt != HELD) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // Strobes are decoded from the transition itself so they register
  // on the same edge the FSM enters HELD / IDLE.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (rep_hit) begin
          press_nxt = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
